sram_responder: RTL and testbench
=================================

Name: sram_responder

Overview:
- Synthesizable device-side emulator of a 16-bit asynchronous SRAM. It answers the SRAM pin interface driven by sram_controller (address, dq, ce_n, we_n, oe_n, ub_n, lb_n) out of on-chip block RAM.
- Used for FPGA bring-up without the external chip, and as a self-checking responder in controller benches.
- Adds protocol checking and access counters.

Parameters:
- SRAM_ADDR_WIDTH, 20, width of the pin address bus.
- SRAM_DATA_WIDTH, 16, width of dq; two byte lanes.
- DEPTH_LOG2, 12, log2 of implemented words; must be <= SRAM_ADDR_WIDTH.
- CNT_WIDTH, 32, width of the access counters.

Ports:
- clk  in  1  system clock; all pin inputs sampled on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_sram_addr  in  SRAM_ADDR_WIDTH  word address.
- io_sram_dq  inout  SRAM_DATA_WIDTH  data bus; driven only during reads.
- i_sram_ce_n  in  1  chip enable, active-low.
- i_sram_we_n  in  1  write enable, active-low.
- i_sram_oe_n  in  1  output enable, active-low.
- i_sram_ub_n  in  1  upper-byte enable, active-low.
- i_sram_lb_n  in  1  lower-byte enable, active-low.
- i_err_clr  in  1  clears the sticky error (single-cycle pulse).
- o_rd_count  out  CNT_WIDTH  number of read accesses.
- o_wr_count  out  CNT_WIDTH  number of committed writes.
- o_err  out  1  sticky protocol error.
- o_err_code  out  2  code of the first error since the last clear.

Behaviour:
- Reset (async, active-high): state IDLE; o_rd_count=0; o_wr_count=0; o_err=0; o_err_code=0; dq high-Z; any pending write discarded. RAM contents are not reset.
- Sampled decode each edge:
  - wr_req = ~ce_n & ~we_n
  - rd_req = ~ce_n & we_n & ~oe_n
  - WE dominates OE.
- FSM states IDLE, READ, WRITE; the next state is chosen from the sampled decode each cycle:
  - IDLE: wr_req -> WRITE; rd_req -> READ; otherwise stay.
  - WRITE: on entry, latch wr_addr_q = addr. Every cycle in WRITE, capture dq lanes whose enable is low into wr_data_q and OR the lane into wr_be_q (last value wins per lane).
  - Exit WRITE when wr_req drops. Next state is READ if rd_req, else IDLE.
  - On the exit edge, commit wr_data_q to RAM[wr_addr_q] with byte enables wr_be_q, and o_wr_count+=1.
  - If wr_be_q is 0 at exit: no RAM update, count still increments.
  - A direct WRITE->WRITE is impossible; a new write needs we_n high for at least one cycle.
  - READ: the RAM is read synchronously at the sampled addr every cycle. dq shows RAM data for the address sampled on the previous edge (latency 1 clk).
  - o_rd_count+=1 on READ entry and on every sampled address change while staying in READ.
  - READ -> WRITE if wr_req; READ -> IDLE if neither request.
- Drive rule: lane drive enables are registered from the sampled (rd_req & lane_en_n==0), then gated combinationally with the live ~ce_n & ~oe_n & we_n. No contention is possible the instant the controller lowers we_n or raises oe_n. Non-enabled lanes are high-Z.
- Read-after-write bypass: if the commit edge reads the same address, the dq data one cycle later is the merged new data (committed lanes new, others old).
- Address aliasing: RAM index = addr[DEPTH_LOG2-1:0].
- Protocol errors (sticky; first code kept until cleared):
  - 1: access (wr_req or rd_req) with ub_n=lb_n=1.
  - 2: address changed while in WRITE. The commit still uses wr_addr_q.
  - 3: addr bits above DEPTH_LOG2 nonzero during an access.
- Error vs clear: an error detected in the same cycle as i_err_clr wins; o_err stays 1 and the code becomes the new code.
- Counters wrap modulo 2^CNT_WIDTH, with no saturation.
- Reset mid-write drops the write: no commit, no count.

Decomposition:
- Shared package sram_pkg holds:
  - sram_state_t enum (IDLE, READ, WRITE)
  - sram_err_t enum (NONE, NO_LANE, ADDR_UNSTABLE, OUT_OF_RANGE)
  - SRAM_LANES constant
  - Lane-width constant
- One sub-module, sram_bram_be: simple dual-port RAM with one write port with byte enables and one synchronous read port; no reset, infers block RAM.
- Bypass merge and FSM stay in sram_responder.

Test Plan:
- Write then read: write 0xBEEF to addr 0x00010 (ub/lb low, we_n low 2 cycles), then read addr 0x00010 -> dq=0xBEEF one cycle after address; o_wr_count=1, o_rd_count=1, o_err=0.
- Byte lanes: preload 0x1234 at addr 5, write 0xAB00 with lb_n=1 -> read gives 0xAB34. A read with ub_n=1 shows upper dq high-Z and lower=0x34.
- Back-to-back write->read: the commit edge enters READ at the same addr 7 -> the next cycle's dq equals the new data (bypass); toggle addr 7->8->7 in READ -> o_rd_count=3.
- Errors:
  - Access with ub_n=lb_n=1 -> o_err=1, code 1.
  - Addr 0x80000 with DEPTH_LOG2=12 -> code stays 1 (first kept).
  - i_err_clr -> o_err=0.
  - Addr change mid-write -> code 2; data lands at the latched address.
- Contention: drop we_n low while oe_n is still low in READ -> dq released in the same cycle (combinational), no X on the bus.
- Reset: assert rst asynchronously mid-write -> dq high-Z at once, counters 0; the later read of that address returns the old data.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the on-chip asynchronous SRAM emulator.
package sram_pkg;

  localparam int SRAM_LANES = 2;
  localparam int LANE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } sram_state_t;

  typedef enum logic [1:0] {
    NONE          = 2'd0,
    NO_LANE       = 2'd1,
    ADDR_UNSTABLE = 2'd2,
    OUT_OF_RANGE  = 2'd3
  } sram_err_t;

endpackage

// File: rtl/sram_bram_be.sv
// Simple dual-port block RAM: byte-enabled write port, registered read port.
// Read-before-write on a same-address collision; no reset so it maps to BRAM.
module sram_bram_be
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LANES      = SRAM_LANES,
  parameter int LW         = LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LANES-1:0]      wr_be,
  input  logic [LANES*LW-1:0]   wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [LANES*LW-1:0]   rd_data
);

  logic [LANES*LW-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en && wr_be[i]) begin
        mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
      end
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Device-side emulator of a 16-bit async SRAM backed by block RAM, with
// protocol checking and access counters. Read data appears one clock after the sampled address.
module sram_responder
  import sram_pkg::*;
#(
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int SRAM_DATA_WIDTH = 16,
  parameter int DEPTH_LOG2      = 12,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [SRAM_ADDR_WIDTH-1:0] i_sram_addr,
  inout  wire  [SRAM_DATA_WIDTH-1:0] io_sram_dq,
  input  logic                       i_sram_ce_n,
  input  logic                       i_sram_we_n,
  input  logic                       i_sram_oe_n,
  input  logic                       i_sram_ub_n,
  input  logic                       i_sram_lb_n,
  input  logic                       i_err_clr,
  output logic [CNT_WIDTH-1:0]       o_rd_count,
  output logic [CNT_WIDTH-1:0]       o_wr_count,
  output logic                       o_err,
  output logic [1:0]                 o_err_code
);

  logic                       wr_req, rd_req, acc, live_oe, out_of_range, commit, rd_cnt_inc;
  logic [SRAM_LANES-1:0]      lane_en, wr_be_q, byp_be_q, drv_q;
  logic [SRAM_ADDR_WIDTH-1:0] wr_addr_q, prev_addr_q;
  logic [SRAM_DATA_WIDTH-1:0] wr_data_q, byp_data_q, rd_data, dq_out;
  logic [CNT_WIDTH-1:0]       rd_count_q, wr_count_q;
  logic                       err_q;
  sram_err_t                  err_code_q, err_new;
  sram_state_t                state_q, state_d;

  assign wr_req       = ~i_sram_ce_n & ~i_sram_we_n;
  assign rd_req       = ~i_sram_ce_n &  i_sram_we_n & ~i_sram_oe_n;
  assign acc          = wr_req | rd_req;
  assign lane_en      = {~i_sram_ub_n, ~i_sram_lb_n};
  assign out_of_range = (i_sram_addr >> DEPTH_LOG2) != '0;

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      IDLE:  if (wr_req) state_d = WRITE; else if (rd_req) state_d = READ;
      WRITE: if (!wr_req) begin
               commit  = 1'b1;
               state_d = rd_req ? READ : IDLE;
             end
      READ:  if (wr_req) state_d = WRITE; else if (!rd_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_cnt_inc = (state_d == READ) && ((state_q != READ) || (i_sram_addr != prev_addr_q));

  always_comb begin
    err_new = NONE;
    if (acc && lane_en == '0)                                   err_new = NO_LANE;
    else if (state_q == WRITE && wr_req && i_sram_addr != wr_addr_q) err_new = ADDR_UNSTABLE;
    else if (acc && out_of_range)                               err_new = OUT_OF_RANGE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_be_q     <= '0;
      prev_addr_q <= '0;
      byp_be_q    <= '0;
      byp_data_q  <= '0;
      drv_q       <= '0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= NONE;
    end else begin
      state_q     <= state_d;
      prev_addr_q <= i_sram_addr;
      drv_q       <= rd_req ? lane_en : '0;
      if (state_d == WRITE) begin
        if (state_q != WRITE) begin
          wr_addr_q <= i_sram_addr;
          wr_be_q   <= lane_en;
        end else begin
          wr_be_q   <= wr_be_q | lane_en;
        end
        for (int i = 0; i < SRAM_LANES; i++) begin
          if (lane_en[i]) wr_data_q[i*LANE_WIDTH +: LANE_WIDTH] <= io_sram_dq[i*LANE_WIDTH +: LANE_WIDTH];
        end
      end
      // The BRAM returns pre-commit data on a same-address collision; remember the lanes to patch.
      byp_be_q   <= (commit && i_sram_addr[DEPTH_LOG2-1:0] == wr_addr_q[DEPTH_LOG2-1:0]) ? wr_be_q : '0;
      byp_data_q <= wr_data_q;
      if (commit)     wr_count_q <= wr_count_q + CNT_WIDTH'(1);
      if (rd_cnt_inc) rd_count_q <= rd_count_q + CNT_WIDTH'(1);
      if (err_new != NONE) begin
        if (!err_q || i_err_clr) begin
          err_q      <= 1'b1;
          err_code_q <= err_new;
        end
      end else if (i_err_clr) begin
        err_q      <= 1'b0;
        err_code_q <= NONE;
      end
    end
  end

  sram_bram_be #(
    .ADDR_WIDTH (DEPTH_LOG2),
    .LANES      (SRAM_LANES),
    .LW         (LANE_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (commit),
    .wr_addr (wr_addr_q[DEPTH_LOG2-1:0]),
    .wr_be   (wr_be_q),
    .wr_data (wr_data_q),
    .rd_addr (i_sram_addr[DEPTH_LOG2-1:0]),
    .rd_data (rd_data)
  );

  // Live pin gating releases the bus in the same instant the controller turns it around.
  assign live_oe = ~i_sram_ce_n & ~i_sram_oe_n & i_sram_we_n;

  for (genvar g = 0; g < SRAM_LANES; g++) begin : g_lane
    assign dq_out[g*LANE_WIDTH +: LANE_WIDTH] = byp_be_q[g] ? byp_data_q[g*LANE_WIDTH +: LANE_WIDTH]
                                                            : rd_data[g*LANE_WIDTH +: LANE_WIDTH];
    assign io_sram_dq[g*LANE_WIDTH +: LANE_WIDTH] = (drv_q[g] && live_oe) ? dq_out[g*LANE_WIDTH +: LANE_WIDTH]
                                                                          : {LANE_WIDTH{1'bz}};
  end

  assign o_rd_count = rd_count_q;
  assign o_wr_count = wr_count_q;
  assign o_err      = err_q;
  assign o_err_code = err_code_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder; an undriven dq bit reads as 1 through the pullups.
`timescale 1ns/1ps
module tb_sram_responder;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int DL = 12;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          ce_n, we_n, oe_n, ub_n, lb_n, err_clr;
  logic [CW-1:0] rd_count, wr_count;
  logic          err;
  logic [1:0]    err_code;
  wire  [DW-1:0] dq;
  logic [DW-1:0] tb_dq;
  logic          tb_drv;

  assign dq = tb_drv ? tb_dq : 'z;
  for (genvar g = 0; g < DW; g++) begin : g_pu
    pullup (dq[g]);
  end

  always #5 clk = ~clk;

  sram_responder #(
    .SRAM_ADDR_WIDTH (AW),
    .SRAM_DATA_WIDTH (DW),
    .DEPTH_LOG2      (DL),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_sram_addr (addr),
    .io_sram_dq  (dq),
    .i_sram_ce_n (ce_n),
    .i_sram_we_n (we_n),
    .i_sram_oe_n (oe_n),
    .i_sram_ub_n (ub_n),
    .i_sram_lb_n (lb_n),
    .i_err_clr   (err_clr),
    .o_rd_count  (rd_count),
    .o_wr_count  (wr_count),
    .o_err       (err),
    .o_err_code  (err_code)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model [4096];
  logic [15:0] exp_q [$];
  logic [15:0] exp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; err_clr = 1'b0; bus_idle();
    repeat (2) step();
    rst = 1'b0;
    step();
    exp_q.delete();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic u, input logic l, input int n);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = u; lb_n = l; addr = a; tb_dq = d; tb_drv = 1'b1;
    repeat (n) step();
    bus_idle();
    step();
    if (!l) model[a[DL-1:0]][7:0]  = d[7:0];
    if (!u) model[a[DL-1:0]][15:8] = d[15:8];
  endtask

  task automatic rd_issue(input logic [AW-1:0] a, input logic u, input logic l);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = u; lb_n = l; addr = a; tb_drv = 1'b0;
    exp_q.push_back({u ? 8'hFF : model[a[DL-1:0]][15:8], l ? 8'hFF : model[a[DL-1:0]][7:0]});
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; err_clr = 1'b0; addr = '0; tb_dq = '0; bus_idle();
    repeat (2) step();
    checks++; if (rd_count !== 0) begin errors++; $display("FAIL reset_rd_count: got %0d expected 0", rd_count); end
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL reset_wr_count: got %0d expected 0", wr_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (err_code !== 2'd0) begin errors++; $display("FAIL reset_err_code: got %0d expected 0", err_code); end
    checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL reset_dq_hiz: got %h expected ffff", dq); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    apply_reset();
    wr(20'h00010, 16'hBEEF, 1'b0, 1'b0, 2);
    rd_issue(20'h00010, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL wr_rd_data: got %h expected %h", dq, exp); end
    checks++; if (wr_count !== 1) begin errors++; $display("FAIL wr_rd_wr_count: got %0d expected 1", wr_count); end
    checks++; if (rd_count !== 1) begin errors++; $display("FAIL wr_rd_rd_count: got %0d expected 1", rd_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_rd_err: got %b expected 0", err); end
    bus_idle(); step();
  endtask

  task automatic test_byte_lanes();
    apply_reset();
    wr(20'h5, 16'h1234, 1'b0, 1'b0, 1);
    wr(20'h5, 16'hAB00, 1'b0, 1'b1, 1);
    rd_issue(20'h5, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL lanes_merge: got %h expected %h", dq, exp); end
    rd_issue(20'h5, 1'b1, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL lanes_upper_hiz: got %h expected %h", dq, exp); end
    checks++; if (rd_count !== 1) begin errors++; $display("FAIL lanes_rd_count: got %0d expected 1", rd_count); end
    bus_idle(); step();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    wr(20'h7, 16'h1111, 1'b0, 1'b0, 1);
    wr(20'h8, 16'h8888, 1'b0, 1'b0, 1);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0; addr = 20'h7; tb_dq = 16'h2222; tb_drv = 1'b1;
    step();
    we_n = 1'b0;
    we_n = 1'b1; oe_n = 1'b0; tb_drv = 1'b0;
    model[7] = 16'h2222;
    exp_q.push_back(16'h2222);
    step();
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL b2b_bypass: got %h expected %h", dq, exp); end
    rd_issue(20'h8, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL b2b_addr8: got %h expected %h", dq, exp); end
    rd_issue(20'h7, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL b2b_addr7: got %h expected %h", dq, exp); end
    checks++; if (rd_count !== 3) begin errors++; $display("FAIL b2b_rd_count: got %0d expected 3", rd_count); end
    checks++; if (wr_count !== 3) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 3", wr_count); end
    bus_idle(); step();
  endtask

  task automatic test_errors();
    apply_reset();
    wr(20'h21, 16'h5555, 1'b0, 1'b0, 1);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b1; lb_n = 1'b1; addr = 20'h3;
    step();
    checks++; if (err !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL err_no_lane: got %b/%0d expected 1/1", err, err_code); end
    ub_n = 1'b0; lb_n = 1'b0; addr = 20'h80000;
    step();
    checks++; if (err !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL err_first_kept: got %b/%0d expected 1/1", err, err_code); end
    bus_idle(); err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err !== 1'b0 || err_code !== 2'd0) begin errors++; $display("FAIL err_clear: got %b/%0d expected 0/0", err, err_code); end
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 20'h20; tb_dq = 16'h3C3C; tb_drv = 1'b1;
    step();
    addr = 20'h21;
    step();
    bus_idle();
    step();
    model[12'h20] = 16'h3C3C;
    checks++; if (err !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL err_addr_unstable: got %b/%0d expected 1/2", err, err_code); end
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; ub_n = 1'b1; lb_n = 1'b1; addr = 20'h3; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++; if (err !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL err_vs_clear: got %b/%0d expected 1/1", err, err_code); end
    rd_issue(20'h20, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL err_latched_addr: got %h expected %h", dq, exp); end
    rd_issue(20'h21, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL err_other_addr: got %h expected %h", dq, exp); end
    bus_idle(); step();
  endtask

  task automatic test_contention();
    apply_reset();
    wr(20'h9, 16'h0F0F, 1'b0, 1'b0, 1);
    rd_issue(20'h9, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL cont_read: got %h expected %h", dq, exp); end
    we_n = 1'b0; #1;
    checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL cont_we_release: got %h expected ffff", dq); end
    we_n = 1'b1; #1;
    checks++; if (dq !== 16'h0F0F) begin errors++; $display("FAIL cont_we_restore: got %h expected 0f0f", dq); end
    oe_n = 1'b1; #1;
    checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL cont_oe_release: got %h expected ffff", dq); end
    bus_idle(); step();
  endtask

  task automatic test_reset_midwrite();
    apply_reset();
    wr(20'h30, 16'hA5A5, 1'b0, 1'b0, 1);
    rd_issue(20'h30, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL rstmid_read: got %h expected %h", dq, exp); end
    #2 rst = 1'b1; #1;
    checks++; if (dq !== 16'hFFFF) begin errors++; $display("FAIL rstmid_dq_hiz: got %h expected ffff", dq); end
    checks++; if (rd_count !== 0 || wr_count !== 0) begin errors++; $display("FAIL rstmid_counts: got %0d/%0d expected 0/0", rd_count, wr_count); end
    bus_idle(); step();
    rst = 1'b0;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 20'h30; tb_dq = 16'h5A5A; tb_drv = 1'b1;
    step(); step();
    #2 rst = 1'b1;
    bus_idle(); step();
    rst = 1'b0;
    step();
    rd_issue(20'h30, 1'b0, 1'b0);
    exp = exp_q.pop_front();
    checks++; if (dq !== exp) begin errors++; $display("FAIL rstmid_old_data: got %h expected %h", dq, exp); end
    checks++; if (wr_count !== 0) begin errors++; $display("FAIL rstmid_no_commit: got %0d expected 0", wr_count); end
    bus_idle(); step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_back_to_back();
    test_errors();
    test_contention();
    test_reset_midwrite();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
